// File: rtl/shift_pkg.sv
// Shared types and constants for the pipelined barrel shifter.
package shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SLL = 2'b00;
    localparam mode_t MODE_SRL = 2'b01;
    localparam mode_t MODE_SRA = 2'b10;
    localparam mode_t MODE_ROL = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One fixed-distance shift step covering all four modes; pure combinational.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  mode_t            mode,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        if (en) begin
            case (mode)
                MODE_SLL: q = {d[WIDTH-1-DIST:0], {DIST{1'b0}}};
                MODE_SRL: q = {{DIST{1'b0}}, d[WIDTH-1:DIST]};
                MODE_SRA: q = {{DIST{d[WIDTH-1]}}, d[WIDTH-1:DIST]};
                MODE_ROL: q = {d[WIDTH-1-DIST:0], d[WIDTH-1:WIDTH-DIST]};
                default:  q = d;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined logarithmic barrel shifter: one registered stage per power-of-two
// distance, largest first, with valid/ready flow control and bubble collapse.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned TAG_W   = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  mode_t              in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int unsigned LAST = SHAMT_W - 1;

    logic [SHAMT_W-1:0]              r_valid;
    logic [SHAMT_W-1:0][WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] r_shamt;
    mode_t [SHAMT_W-1:0]             r_mode;
    logic [SHAMT_W-1:0][TAG_W-1:0]   r_tag;

    logic [SHAMT_W-1:0]              w_up_valid;
    logic [SHAMT_W-1:0][WIDTH-1:0]   w_up_data;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] w_up_shamt;
    mode_t [SHAMT_W-1:0]             w_up_mode;
    logic [SHAMT_W-1:0][TAG_W-1:0]   w_up_tag;
    logic [SHAMT_W-1:0][WIDTH-1:0]   w_q;
    logic [SHAMT_W-1:0]              w_load;

    // Stage 0 is fed by the input port, every other stage by its predecessor.
    always_comb begin
        w_up_valid[0] = in_valid;
        w_up_data[0]  = in_data;
        w_up_shamt[0] = in_shamt;
        w_up_mode[0]  = in_mode;
        w_up_tag[0]   = in_tag;
        for (int unsigned s = 1; s < SHAMT_W; s++) begin
            w_up_valid[s] = r_valid[s-1];
            w_up_data[s]  = r_data[s-1];
            w_up_shamt[s] = r_shamt[s-1];
            w_up_mode[s]  = r_mode[s-1];
            w_up_tag[s]   = r_tag[s-1];
        end
    end

    // A stage may load when it is empty or any slot downstream frees up this cycle.
    always_comb begin
        logic v_free;
        w_load = '0;
        for (int unsigned s = 0; s < SHAMT_W; s++) begin
            v_free = out_ready;
            for (int unsigned j = s + 1; j < SHAMT_W; j++) begin
                v_free = v_free | ~r_valid[j];
            end
            w_load[s] = ~r_valid[s] | v_free;
        end
    end

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << (LAST - s))
        ) u_stage (
            .d    (w_up_data[s]),
            .en   (w_up_shamt[s][LAST-s]),
            .mode (w_up_mode[s]),
            .q    (w_q[s])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_shamt <= '0;
            r_mode  <= '0;
            r_tag   <= '0;
        end else begin
            for (int unsigned s = 0; s < SHAMT_W; s++) begin
                if (w_load[s]) begin
                    r_valid[s] <= w_up_valid[s];
                    if (w_up_valid[s]) begin
                        r_data[s]  <= w_q[s];
                        r_shamt[s] <= w_up_shamt[s];
                        r_mode[s]  <= w_up_mode[s];
                        r_tag[s]   <= w_up_tag[s];
                    end
                end
            end
        end
    end

    // Shift amount and mode are dead once the final stage has been applied.
    logic w_unused_last;
    assign w_unused_last = ^{r_shamt[LAST], r_mode[LAST]};

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[LAST];
    assign out_data  = r_data[LAST];
    assign out_tag   = r_tag[LAST];
    assign busy      = |r_valid;

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined logarithmic barrel shifter for the processor datapath.
- Generalises the single fixed shift-by-4 stage: one stage per power-of-two shift amount (16, 8, 4, 2, 1 for 32 bits), each registered.
- Supports four modes: logical left, logical right, arithmetic right, rotate left.
- Valid/ready handshake on both sides, full backpressure; a tag travels with each operation so the issuing unit can match results.

Parameters:
- WIDTH, 32, data width; must be a power of two, at least 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width; also the pipeline depth (number of stages).
- TAG_W, 5, width of the opaque tag carried alongside the data.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  pipeline can accept the input this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of that result.
- busy  out  1  OR of all stage valid bits.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - While reset_n=0, all stage valid bits clear immediately.
  - At reset: out_valid=0 and busy=0. out_data and out_tag are 0, because the data registers also reset to 0.
  - in_ready=1 as soon as reset deasserts.
- Stage structure:
  - Stages s=0..SHAMT_W-1. Each holds valid, data, remaining shamt bits, mode and tag.
  - Stage s applies shift distance 2^(SHAMT_W-1-s) when shamt bit (SHAMT_W-1-s) is 1, and passes data through when the bit is 0.
  - Stage 0 operates on in_data. Stage s>0 operates on the register output of stage s-1.
  - The stage shift is combinational in front of the stage's register.
- Modes (d = stage input, k = stage distance):
  - SLL: zero-fill on the right.
  - SRL: zero-fill on the left.
  - SRA: fill with d[WIDTH-1]. The sign is preserved through every stage because d already carries the sign from the previous stage.
  - ROL: bits shifted out at the top re-enter at the bottom.
- Latency:
  - An operation accepted at edge N is visible on out_data/out_valid after edge N+SHAMT_W-1, i.e. it sits in the last stage register. That is SHAMT_W register stages (5 for WIDTH=32).
  - With out_ready held at 1, throughput is one operation per cycle.
- Handshake:
  - Stage s advances when its downstream is free: the next stage is empty or is itself advancing.
  - For the last stage, "advancing" means out_valid & out_ready.
  - in_ready = !v[0] | advance[0], where advance[0] = stage 1 empty or advancing.
  - Accept occurs when in_valid & in_ready.
  - Stalled stages hold data, mode, tag and valid unchanged.
  - Bubbles collapse: an empty stage accepts from upstream even while downstream is stalled.
  - out_data and out_tag stay stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - shamt=0 in any mode: output equals input.
  - Full pipeline with out_ready=0: all SHAMT_W stages fill, then in_ready=0. No operation is lost or duplicated.
  - Simultaneous output pop and input push while full: both occur in the same cycle and the pipeline stays full.
  - Reset mid-operation: every in-flight operation is discarded and none is emitted after reset.
  - No input is sampled while in_valid=0. Data registers may update with don't-care values, but the valid bits must not change.
  - in_mode and in_shamt are sampled only on accept.

Decomposition:
- Package shift_pkg:
  - Mode localparams MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROL=2'b11.
  - A typedef for the 2-bit mode.
- Sub-module shift_stage:
  - Parameters WIDTH and DIST.
  - Combinational: inputs d, en, mode; output q.
  - Implements one distance for all four modes.
  - Instantiated SHAMT_W times in a generate loop.
- The top level holds the pipeline registers and handshake logic.

Test Plan:
- Reset: assert reset_n=0 mid-stream with 3 ops in flight, then release → out_valid=0 and busy=0 immediately. No outputs appear in the following 10 cycles with in_valid=0.
- Modes, WIDTH=32, out_ready=1:
  - SLL 0x0000_00F1 by 4 → 0x0000_0F10.
  - SRL 0x8000_0000 by 31 → 0x0000_0001.
  - SRA 0x8000_0000 by 4 → 0xF800_0000.
  - ROL 0x8000_0001 by 1 → 0x0000_0003.
  - Each result appears exactly 5 cycles after accept, with its tag.
- Identity: all modes with shamt=0 on 0xDEAD_BEEF → 0xDEAD_BEEF.
- Backpressure:
  - Hold out_ready=0 and stream 7 ops with tags 0..6 → in_ready drops after 5 accepts. out_data holds tag 0's result stable.
  - Then set out_ready=1 → tags 0..6 emerge in order, one per cycle, with no gaps after refill.
- Bubble collapse:
  - Issue op A, idle 2 cycles, then op B, with out_ready=0 until both have entered.
  - Expected: A occupies stage 4 and B stage 3, with no stall of B before stage 3.
- Random scoreboard: 10k random data/shamt/mode with random in_valid and out_ready → every output matches the reference model in order, with no drops or duplicates.
